// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard_if
//  Description : Decode-side bundle for the hazard scoreboard. It carries the
//                source/destination operands in, and the stall, bypass
//                selects and stall counter out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_scoreboard_if #(
    parameter int AW   = 5,
    parameter int NSRC = 2,
    parameter int LW   = 3,
    parameter int TAGW = 2
);
    logic [NSRC*AW-1:0]   src_addr;
    logic [NSRC-1:0]      src_used;
    logic                 issue_valid;
    logic [AW-1:0]        issue_rd;
    logic [LW-1:0]        issue_lat;
    logic [TAGW-1:0]      issue_tag;
    logic                 flush;
    logic                 stallD;
    logic                 stallF;
    logic                 issue_ack;
    logic [NSRC-1:0]      fwd_en;
    logic [NSRC*TAGW-1:0] fwd_sel;
    logic [31:0]          stall_cycles;

    // Decode side: presents the instruction, consumes stall and bypass info.
    modport master (
        output src_addr, src_used, issue_valid, issue_rd, issue_lat, issue_tag, flush,
        input  stallD, stallF, issue_ack, fwd_en, fwd_sel, stall_cycles
    );

    // Scoreboard side.
    modport slave (
        input  src_addr, src_used, issue_valid, issue_rd, issue_lat, issue_tag, flush,
        output stallD, stallF, issue_ack, fwd_en, fwd_sel, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Per-register outstanding-write countdown scoreboard. Produces
//                the decode/fetch stall, per-source bypass selects and a
//                saturating stall-cycle counter for variable-latency units.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int NSRC     = 2,
    parameter int LW       = 3,
    parameter int TAGW     = 2,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst,
    hazard_scoreboard_if.slave hs
);

    localparam logic [LW-1:0] c_LAT_ONE   = LW'(1);
    localparam logic [31:0]   c_STALL_MAX = 32'hFFFF_FFFF;

    // Remaining cycles until each register's result appears on its bypass bus,
    // and the bus that will carry it.
    logic [LW-1:0]   r_cnt [NREG];
    logic [TAGW-1:0] r_tag [NREG];
    logic [31:0]     r_stall_cycles;

    logic [LW-1:0]        w_eff_lat;
    logic [NSRC-1:0]      w_src_haz;
    logic [NSRC-1:0]      w_fwd_en;
    logic [NSRC*TAGW-1:0] w_fwd_sel;
    logic                 w_waw;
    logic                 w_stall;
    logic                 w_ack;
    logic                 w_rd_writable;

    // A zero latency request is treated as a single-cycle ALU result.
    always_comb begin
        w_eff_lat = (hs.issue_lat == '0) ? c_LAT_ONE : hs.issue_lat;
    end

    // Per-source hazard / bypass decode; all comparisons use pre-issue counts.
    generate
        for (genvar i = 0; i < NSRC; i++) begin : g_src
            logic [AW-1:0] w_addr;
            logic [LW-1:0] w_cnt;
            logic          w_live;

            assign w_addr = hs.src_addr[i*AW +: AW];
            assign w_cnt  = r_cnt[w_addr];
            // Hardwired zero register never blocks and never forwards.
            assign w_live = hs.src_used[i] && !((ZERO_REG != 0) && (w_addr == '0));

            assign w_src_haz[i]               = w_live && (w_cnt > c_LAT_ONE);
            assign w_fwd_en[i]                = w_live && (w_cnt == c_LAT_ONE);
            assign w_fwd_sel[i*TAGW +: TAGW]  = (w_live && (w_cnt == c_LAT_ONE)) ? r_tag[w_addr] : '0;
        end
    endgenerate

    // Stall/issue decision; a write-after-write stall keeps writebacks in order.
    always_comb begin
        w_waw         = hs.issue_valid && (r_cnt[hs.issue_rd] > w_eff_lat);
        w_stall       = !hs.flush && ((|w_src_haz) || w_waw);
        w_ack         = hs.issue_valid && !w_stall && !hs.flush;
        w_rd_writable = !((ZERO_REG != 0) && (hs.issue_rd == '0));
    end

    assign hs.stallD       = w_stall;
    assign hs.stallF       = w_stall;
    assign hs.issue_ack    = w_ack;
    assign hs.fwd_en       = w_fwd_en;
    assign hs.fwd_sel      = w_fwd_sel;
    assign hs.stall_cycles = r_stall_cycles;

    // Countdown drain for every register; an accepted issue reloads its target.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                r_cnt[r] <= '0;
                r_tag[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (w_ack && w_rd_writable && (hs.issue_rd == AW'(r))) begin
                    r_cnt[r] <= w_eff_lat;
                    r_tag[r] <= hs.issue_tag;
                end else if (r_cnt[r] != '0) begin
                    r_cnt[r] <= r_cnt[r] - c_LAT_ONE;
                end
            end
        end
    end

    // Saturating count of cycles spent stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != c_STALL_MAX)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

endmodule
`default_nettype wire
